// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding
// and the digit counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_e;

    // Counter must hold 0..n-1 and is never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// One digit slice of the subtractor: a ripple of full-adder cells computing
// {c_out, s} = a + ~b + c_in, where c_in is the inverted borrow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module sub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] s,
    output logic             c_out
);
    logic [DIGIT:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder u_fa (
            .a  (a[i]),
            .b  (~b[i]),
            .ci (carry[i]),
            .s  (s[i]),
            .co (carry[i+1])
        );
    end

    assign c_out = carry[DIGIT];
endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor D = A - B - BI, LSB first, DIGIT bits per cycle,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BI,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             Z,
    output logic             V,
    output logic [1:0]       dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and InReady never looks at
    // InValid (it depends only on state and, in DONE, on OutReady).

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    serial_state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bo_q, bo_d;
    logic             z_q, z_d;
    logic             v_q, v_d;

    logic             accept;
    logic             last_digit;
    logic [DIGIT-1:0] dig_s;
    logic             dig_c;
    logic [WIDTH-1:0] res_shift;

    sub_digit #(
        .DIGIT (DIGIT)
    ) u_sub_digit (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .c_in  (c_q),
        .s     (dig_s),
        .c_out (dig_c)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (InValid)    state_d = RUN;
            RUN:  if (last_digit) state_d = DONE;
            DONE: if (OutReady)   state_d = InValid ? RUN : IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        InReady  = 1'b0;
        OutValid = 1'b0;
        unique case (state_q)
            IDLE:    InReady = 1'b1;
            RUN:     InReady = 1'b0;
            DONE: begin
                InReady  = OutReady;
                OutValid = 1'b1;
            end
            default: InReady = 1'b0;
        endcase
    end

    assign accept     = InValid & InReady;
    assign last_digit = (state_q == RUN) && (cnt_q == LAST);
    assign dbg_state  = state_q;

    // New digits enter the result register from the MSB side.
    assign res_shift = (res_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

    // ---------------- Datapath next values ----------------
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        bo_d    = bo_q;
        z_d     = z_q;
        v_d     = v_q;

        if (accept) begin
            a_d     = A;
            b_d     = B;
            res_d   = '0;
            c_d     = ~BI;
            cnt_d   = '0;
            a_msb_d = A[WIDTH-1];
            b_msb_d = B[WIDTH-1];
        end else if (state_q == RUN) begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            res_d = res_shift;
            c_d   = dig_c;
            cnt_d = cnt_q + CW'(1);
            // Result outputs live in their own registers so they stay put
            // while the next operation shifts through res_q.
            if (last_digit) begin
                d_d  = res_shift;
                bo_d = ~dig_c;
                z_d  = (res_shift == '0);
                v_d  = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            z_q     <= z_d;
            v_q     <= v_d;
        end
    end

    assign D  = d_q;
    assign BO = bo_q;
    assign Z  = z_q;
    assign V  = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: one DIGIT=1 and one DIGIT=4 instance,
// table-driven vectors plus backpressure, back-to-back and reset sequences.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DIGIT=1 instance
    logic        iv1, ir1, bi1, ov1, or1, bo1, z1, v1;
    logic [15:0] a1, b1, d1;
    logic [1:0]  st1;

    // DIGIT=4 instance
    logic        iv4, ir4, bi4, ov4, or4, bo4, z4, v4;
    logic [15:0] a4, b4, d4;
    logic [1:0]  st4;

    serial_subtractor #(.WIDTH(16), .DIGIT(1)) dut1 (
        .CLK(clk), .RST(rst), .InValid(iv1), .InReady(ir1), .A(a1), .B(b1),
        .BI(bi1), .OutValid(ov1), .OutReady(or1), .D(d1), .BO(bo1), .Z(z1),
        .V(v1), .dbg_state(st1)
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut4 (
        .CLK(clk), .RST(rst), .InValid(iv4), .InReady(ir4), .A(a4), .B(b4),
        .BI(bi4), .OutValid(ov4), .OutReady(or4), .D(d4), .BO(bo4), .Z(z4),
        .V(v4), .dbg_state(st4)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    typedef struct {
        string       nm;
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] d;
        logic        bo;
        logic        z;
        logic        v;
    } vec_t;

    vec_t vecs[7];

    // ---------------- driver for the DIGIT=4 instance ----------------
    // Called with the DUT idle; leaves it idle. OutReady is assumed high.
    task automatic run_op4(input string nm, input logic [15:0] a, input logic [15:0] b,
                           input logic bi, input logic [15:0] ed, input logic ebo,
                           input logic ez, input logic ev);
        int cyc;
        @(negedge clk);
        a4  = a;
        b4  = b;
        bi4 = bi;
        iv4 = 1'b1;
        check({nm, " in_ready"}, 32'(ir4), 32'd1);
        @(posedge clk);
        #1;
        iv4 = 1'b0;
        a4  = ~a;
        b4  = ~b;
        bi4 = ~bi;
        cyc = 0;
        while (!ov4 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({nm, " latency"}, 32'(cyc), 32'd4);
        check({nm, " d"},  32'(d4),  32'(ed));
        check({nm, " bo"}, 32'(bo4), 32'(ebo));
        check({nm, " z"},  32'(z4),  32'(ez));
        check({nm, " v"},  32'(v4),  32'(ev));
        @(posedge clk);
        #1;
        check({nm, " popped"}, 32'(ov4), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"sub1",     16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"zero_m1",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"ovf_neg",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{"equal",    16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{"bi_zero",  16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{"ovf_pos",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{"bi_small", 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; bi1 = 1'b0;
        iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; bi4 = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst dut1 outs", {27'd0, ov1, bo1, z1, v1, ir1}, 32'h1);
        check("rst dut1 d",    32'(d1), 32'd0);
        check("rst dut4 outs", {27'd0, ov4, bo4, z4, v4, ir4}, 32'h1);
        check("rst dut4 d",    32'(d4), 32'd0);
        check("rst dut4 state", 32'(st4), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;

        // ---------------- DIGIT=1: 16-cycle latency ----------------
        begin
            int cyc;
            @(negedge clk);
            a1 = 16'h1234; b1 = 16'h0234; bi1 = 1'b0; iv1 = 1'b1;
            @(posedge clk);
            #1;
            iv1 = 1'b0;
            cyc = 0;
            while (!ov1 && cyc < 60) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check("d1 latency", 32'(cyc), 32'd16);
            check("d1 d",  32'(d1),  32'h1000);
            check("d1 bo", 32'(bo1), 32'd0);
            check("d1 z",  32'(z1),  32'd0);
            check("d1 v",  32'(v1),  32'd0);
        end

        // ---------------- DIGIT=4: vector table ----------------
        for (int i = 0; i < 7; i++) begin
            run_op4(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].bi,
                    vecs[i].d, vecs[i].bo, vecs[i].z, vecs[i].v);
        end

        // ---------------- backpressure ----------------
        begin
            int cyc;
            logic [19:0] snap;
            or4 = 1'b0;
            @(negedge clk);
            a4 = 16'h0005; b4 = 16'h0003; bi4 = 1'b1; iv4 = 1'b1;
            @(posedge clk);
            #1;
            iv4 = 1'b0;
            cyc = 0;
            while (!ov4 && cyc < 40) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check("bp latency", 32'(cyc), 32'd4);
            check("bp d", 32'(d4), 32'h0001);
            snap = {ov4, ir4, bo4, z4, d4};
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                #1;
                check($sformatf("bp hold%0d", k), 32'({ov4, ir4, bo4, z4, d4}),
                      32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0001}));
                check($sformatf("bp snap%0d", k), 32'({ov4, ir4, bo4, z4, d4, v4}), 32'({snap, 1'b0}));
            end
            @(negedge clk);
            or4 = 1'b1;
            #1;
            check("bp in_ready follows", 32'(ir4), 32'd1);
            @(posedge clk);
            #1;
            check("bp popped", 32'(ov4), 32'd0);
            check("bp idle", 32'(st4), 32'(IDLE));
        end

        // ---------------- back-to-back stream ----------------
        begin
            logic [15:0] sa[3];
            logic [15:0] sb[3];
            int acc_edge[3];
            int res_edge[3];
            int k, nres, cyc, idle_seen;
            logic acc;
            sa[0] = 16'h1234; sb[0] = 16'h0234; exp_q.push_back(16'h1000);
            sa[1] = 16'h0000; sb[1] = 16'h0001; exp_q.push_back(16'hFFFF);
            sa[2] = 16'h8000; sb[2] = 16'h0001; exp_q.push_back(16'h7FFF);
            k = 0; nres = 0; cyc = 0; idle_seen = 0;
            @(posedge clk);
            #1;
            a4 = sa[0]; b4 = sb[0]; bi4 = 1'b0; iv4 = 1'b1;
            while (nres < 3 && cyc < 100) begin
                @(negedge clk);
                acc = iv4 & ir4;
                @(posedge clk);
                cyc++;
                #1;
                if (acc) begin
                    acc_edge[k] = cyc;
                    k++;
                    if (k < 3) begin
                        a4 = sa[k]; b4 = sb[k];
                    end else begin
                        iv4 = 1'b0;
                    end
                end
                if (k > 0 && st4 == IDLE) idle_seen++;
                if (ov4) begin
                    res_edge[nres] = cyc;
                    check($sformatf("b2b d%0d", nres), 32'(d4), 32'(exp_q.pop_front()));
                    nres++;
                end
            end
            iv4 = 1'b0;
            check("b2b results", 32'(nres), 32'd3);
            check("b2b accepts", 32'(k), 32'd3);
            check("b2b no idle", 32'(idle_seen), 32'd0);
            if (nres == 3 && k == 3) begin
                check("b2b res gap1", 32'(res_edge[1] - res_edge[0]), 32'd5);
                check("b2b res gap2", 32'(res_edge[2] - res_edge[1]), 32'd5);
                check("b2b acc gap1", 32'(acc_edge[1] - acc_edge[0]), 32'd5);
                check("b2b acc gap2", 32'(acc_edge[2] - acc_edge[1]), 32'd5);
            end
            @(posedge clk);
            #1;
        end

        // ---------------- reset during RUN ----------------
        @(negedge clk);
        a4 = 16'h1234; b4 = 16'h0001; bi4 = 1'b0; iv4 = 1'b1;
        @(posedge clk);
        #1;
        iv4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rst_run state before", 32'(st4), 32'(RUN));
        rst = 1'b1;
        #1;
        check("rst_run out_valid", 32'(ov4), 32'd0);
        check("rst_run in_ready",  32'(ir4), 32'd1);
        check("rst_run state",     32'(st4), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        run_op4("after_rst", 16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
